// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the SSD1306-class OLED driver:
//   - oled_state_t : top-level sequencing states
//   - N_INIT       : number of command bytes sent after panel reset
//   - SCAN_W       : width of the {page, column, bit} scan counter
//   - init_rom()   : power-up command sequence (horizontal addressing,
//                    full 128x8-page window, charge pump on, display on)
//   - small state-decode helpers used for the registered SPI controls
// -----------------------------------------------------------------------------
package oled_pkg;

  typedef enum logic [2:0] {
    ST_RST_LO  = 3'd0,
    ST_RST_HI  = 3'd1,
    ST_INIT    = 3'd2,
    ST_PRIME   = 3'd3,
    ST_STREAM  = 3'd4
  } oled_state_t;

  localparam int N_INIT = 31;
  localparam int ROM_AW = 5;
  localparam int SCAN_W = 13;

  // Command sequence; the window commands (21/22) make the GDDRAM pointer
  // wrap back to page 0, column 0 after the 1024th data byte of a frame.
  function automatic logic [7:0] init_rom(input logic [ROM_AW-1:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:  b = 8'hAE;  // display off
      5'd1:  b = 8'hD5;  // clock divide
      5'd2:  b = 8'h80;
      5'd3:  b = 8'hA8;  // multiplex ratio
      5'd4:  b = 8'h3F;
      5'd5:  b = 8'hD3;  // display offset
      5'd6:  b = 8'h00;
      5'd7:  b = 8'h40;  // start line 0
      5'd8:  b = 8'h8D;  // charge pump
      5'd9:  b = 8'h14;
      5'd10: b = 8'h20;  // memory mode
      5'd11: b = 8'h00;  // horizontal addressing
      5'd12: b = 8'hA1;  // segment remap
      5'd13: b = 8'hC8;  // COM scan direction
      5'd14: b = 8'hDA;  // COM pins
      5'd15: b = 8'h12;
      5'd16: b = 8'h81;  // contrast
      5'd17: b = 8'hCF;
      5'd18: b = 8'hD9;  // precharge
      5'd19: b = 8'hF1;
      5'd20: b = 8'hDB;  // VCOMH
      5'd21: b = 8'h40;
      5'd22: b = 8'hA4;  // resume from RAM
      5'd23: b = 8'hA6;  // normal (non-inverted)
      5'd24: b = 8'h21;  // column window
      5'd25: b = 8'h00;
      5'd26: b = 8'h7F;
      5'd27: b = 8'h22;  // page window
      5'd28: b = 8'h00;
      5'd29: b = 8'h07;
      5'd30: b = 8'hAF;  // display on
      default: b = 8'hE3;  // NOP, unreachable
    endcase
    return b;
  endfunction

  // Chip select is active only while bytes are really clocked out.
  function automatic logic spi_selected(input oled_state_t s);
    return (s == ST_INIT) || (s == ST_STREAM);
  endfunction

  // Display-data phase (also what the renderer sees on dc).
  function automatic logic is_data_state(input oled_state_t s);
    return (s == ST_PRIME) || (s == ST_STREAM);
  endfunction

  // Bit-slot divider runs in every state that advances per bit slot.
  function automatic logic slot_running(input oled_state_t s);
    return (s == ST_INIT) || (s == ST_PRIME) || (s == ST_STREAM);
  endfunction

endpackage

// File: rtl/oled_spi_shift.sv
// -----------------------------------------------------------------------------
// oled_spi_shift
// Bit-slot divider, SPI mode-0 clock generator and 8-bit MSB-first shifter.
// A bit slot is 2*CLK_DIV clks: SCLK low for the first half, high for the
// second. The shifter only moves at slot boundaries, so MOSI changes only at
// the start of a slot and is stable across the SCLK rising edge.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_run         divider runs in the coming cycle (next-state decode)
//   i_sclk_en     SCLK may toggle in the coming cycle (next-state decode)
//   i_load        load i_load_data into the shifter at this edge
//   i_load_data   byte to transmit, MSB first
//   o_slot_end    high during the last clk of a bit slot
//   o_sclk        SPI clock (registered, idles low)
//   o_mosi        SPI data (MSB of the shifter)
// -----------------------------------------------------------------------------
module oled_spi_shift #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic       i_sclk_en,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  output logic       o_slot_end,
  output logic       o_sclk,
  output logic       o_mosi
);

  localparam int SLOT = 2 * CLK_DIV;
  localparam int DW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SLOT - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);

  logic [DW-1:0] r_div;
  logic          r_run;
  logic          r_sclk;
  logic [7:0]    r_shift;

  logic [DW-1:0] w_div_next;
  logic          w_slot_end;

  // Slot end only counts once the divider has actually been running, so the
  // first cycle of a run always starts a fresh slot at phase 0.
  assign w_slot_end = r_run && (r_div == DIV_LAST);

  always_comb begin
    w_div_next = '0;
    if (i_run && r_run && !w_slot_end) begin
      w_div_next = r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_shift <= 8'h00;
    end else begin
      r_run  <= i_run;
      r_div  <= w_div_next;
      // SCLK is registered from the phase the divider is about to enter,
      // which keeps it glitch-free and aligned with r_div.
      r_sclk <= i_sclk_en && (w_div_next >= DIV_HALF);
      if (i_load) begin
        r_shift <= i_load_data;
      end else if (w_slot_end) begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end

  assign o_slot_end = w_slot_end;
  assign o_sclk     = r_sclk;
  assign o_mosi     = r_shift[7];

endmodule

// File: rtl/oled_driver.sv
// -----------------------------------------------------------------------------
// oled_driver
// Drives an SSD1306-class 128x64 OLED over 4-wire SPI. After reset it pulses
// the panel reset, sends the command ROM, runs one silent priming byte and
// then streams display data forever, scanning the renderer with row/col.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   row[2:0]    current page presented to the renderer
//   col[9:0]    {column[6:0], bit[2:0]} presented to the renderer
//   dc          0 = command byte, 1 = display data (panel and renderer)
//   data[7:0]   renderer byte for the scan position, bit0 = top pixel row
//   sclk        SPI clock, mode 0
//   mosi        SPI data
//   cs_n        SPI chip select
//   oled_res_n  panel reset
// -----------------------------------------------------------------------------
module oled_driver
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] row,
  output logic [9:0] col,
  output logic       dc,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       oled_res_n
);

  localparam int TW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [TW-1:0]     TIMER_LAST = TW'(RST_CYCLES - 1);
  localparam logic [ROM_AW-1:0] ROM_LAST   = ROM_AW'(N_INIT - 1);

  oled_state_t        r_state;
  logic [TW-1:0]      r_timer;
  logic [2:0]         r_bit;
  logic [ROM_AW-1:0]  r_rom_idx;
  logic [SCAN_W-1:0]  r_scan;
  logic               r_dc;
  logic               r_cs_n;
  logic               r_res_n;

  oled_state_t        w_state_next;
  logic [TW-1:0]      w_timer_next;
  logic [2:0]         w_bit_next;
  logic [ROM_AW-1:0]  w_rom_idx_next;
  logic [ROM_AW-1:0]  w_rom_idx_inc;
  logic [SCAN_W-1:0]  w_scan_next;
  logic               w_load;
  logic [7:0]         w_load_data;
  logic               w_slot_end;
  logic               w_run;
  logic               w_sclk_en;

  assign w_rom_idx_inc = r_rom_idx + 1'b1;

  // Next-state, counters and shifter load strobe.
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_bit_next     = r_bit;
    w_rom_idx_next = r_rom_idx;
    w_scan_next    = r_scan;
    w_load         = 1'b0;
    w_load_data    = 8'h00;

    case (r_state)
      ST_RST_LO: begin
        w_scan_next = '0;
        if (r_timer == TIMER_LAST) begin
          w_timer_next = '0;
          w_state_next = ST_RST_HI;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end

      ST_RST_HI: begin
        w_scan_next = '0;
        if (r_timer == TIMER_LAST) begin
          w_timer_next   = '0;
          w_state_next   = ST_INIT;
          // First command byte goes into the shifter on INIT entry so the
          // first slot already carries its MSB.
          w_load         = 1'b1;
          w_load_data    = init_rom('0);
          w_rom_idx_next = '0;
          w_bit_next     = '0;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end

      ST_INIT: begin
        w_scan_next = '0;
        if (w_slot_end) begin
          w_bit_next = r_bit + 1'b1;
          if (r_bit == 3'd7) begin
            if (r_rom_idx == ROM_LAST) begin
              w_state_next = ST_PRIME;
            end else begin
              w_rom_idx_next = w_rom_idx_inc;
              w_load         = 1'b1;
              w_load_data    = init_rom(w_rom_idx_inc);
            end
          end
        end
      end

      ST_PRIME, ST_STREAM: begin
        if (w_slot_end) begin
          w_scan_next = r_scan + 1'b1;
          // The renderer has held this column's byte since bit 0; it is
          // shifted out during the next column's eight slots. PRIME fills
          // the pipeline so the first byte on the wire is page 0, column 0.
          if (r_scan[2:0] == 3'd7) begin
            w_load      = 1'b1;
            w_load_data = data;
            if (r_state == ST_PRIME) begin
              w_state_next = ST_STREAM;
            end
          end
        end
      end

      default: begin
        w_state_next = ST_RST_LO;
        w_timer_next = '0;
        w_scan_next  = '0;
      end
    endcase
  end

  // Shifter/divider controls follow the state being entered so that the
  // registered SCLK and chip select change on the same edge as the FSM.
  assign w_run     = slot_running(w_state_next);
  assign w_sclk_en = spi_selected(w_state_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RST_LO;
      r_timer   <= '0;
      r_bit     <= '0;
      r_rom_idx <= '0;
      r_scan    <= '0;
      r_dc      <= 1'b0;
      r_cs_n    <= 1'b1;
      r_res_n   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit     <= w_bit_next;
      r_rom_idx <= w_rom_idx_next;
      r_scan    <= w_scan_next;
      r_dc      <= is_data_state(w_state_next);
      r_cs_n    <= !spi_selected(w_state_next);
      r_res_n   <= (w_state_next != ST_RST_LO);
    end
  end

  oled_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (w_run),
    .i_sclk_en   (w_sclk_en),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .o_slot_end  (w_slot_end),
    .o_sclk      (sclk),
    .o_mosi      (mosi)
  );

  assign row        = r_scan[12:10];
  assign col        = r_scan[9:0];
  assign dc         = r_dc;
  assign cs_n       = r_cs_n;
  assign oled_res_n = r_res_n;

endmodule

// File: tb/tb_oled_driver.sv
// -----------------------------------------------------------------------------
// tb_oled_driver
// Two instances: CLK_DIV=1 for protocol/content/reset checks, CLK_DIV=3 for
// SCLK shape and MOSI stability. Both use RST_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_oled_driver;

  logic       clk;
  logic       rst_n, rst3_n;
  logic [2:0] row, row3;
  logic [9:0] col, col3;
  logic       dc, dc3;
  logic [7:0] data, data3;
  logic       sclk, sclk3, mosi, mosi3, cs_n, cs3_n, res_n, res3_n;

  bit  mode;
  int  cyc;
  int  n_cmp, n_bad;

  oled_driver #(.CLK_DIV(1), .RST_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .dc(dc), .data(data),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .oled_res_n(res_n)
  );

  oled_driver #(.CLK_DIV(3), .RST_CYCLES(4)) dut3 (
    .clk(clk), .rst_n(rst3_n), .row(row3), .col(col3), .dc(dc3), .data(data3),
    .sclk(sclk3), .mosi(mosi3), .cs_n(cs3_n), .oled_res_n(res3_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Renderer model: mode 0 -> {page, column[4:0]}; mode 1 -> one lit column.
  function automatic logic [7:0] render(input logic [2:0] r, input logic [9:0] c, input bit m);
    if (m) return (c[9:3] == 7'd37) ? 8'hFF : 8'h00;
    return {r, c[7:3]};
  endfunction

  initial begin
    data = 8'h00;
    data3 = 8'h00;
    forever begin
      @(negedge clk);
      data  = render(row, col, mode);
      data3 = render(row3, col3, 1'b0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // ---------------- SPI monitor for the CLK_DIV=1 instance ----------------
  logic [7:0]  init_bytes[$];
  logic [7:0]  data_bytes[$];
  int          wrap_bytes[$];
  int          wrap_pulses[$];
  int          bitcnt, pulse_cnt, t_prime, t_rise;
  bit          got_prime, got_rise;
  logic [7:0]  sh;
  logic        sclk_prev, dc_prev;
  logic [12:0] scan_prev;

  initial begin
    bitcnt = 0; sh = 8'h00; sclk_prev = 1'b0; dc_prev = 1'b0; scan_prev = '0;
    pulse_cnt = 0; got_prime = 1'b0; got_rise = 1'b0; t_prime = 0; t_rise = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bitcnt = 0;
      end else begin
        if (cs_n) begin
          bitcnt = 0;
        end else if (sclk && !sclk_prev) begin
          sh = {sh[6:0], mosi};
          bitcnt++;
          if (bitcnt == 8) begin
            bitcnt = 0;
            if (dc) data_bytes.push_back(sh);
            else    init_bytes.push_back(sh);
          end
        end
        if (dc && !dc_prev && !got_prime) begin
          got_prime = 1'b1;
          t_prime = cyc;
        end
        if (got_prime && !got_rise && dc && sclk && !sclk_prev) begin
          got_rise = 1'b1;
          t_rise = cyc;
        end
        if ({row, col} == 13'h1FFF && scan_prev != 13'h1FFF) pulse_cnt++;
        if (scan_prev == 13'h1FFF && {row, col} == 13'h0000) begin
          wrap_bytes.push_back(data_bytes.size());
          wrap_pulses.push_back(pulse_cnt);
          pulse_cnt = 0;
        end
      end
      sclk_prev = sclk;
      dc_prev = dc;
      scan_prev = {row, col};
    end
  end

  // ---------------- SCLK/MOSI shape monitor for CLK_DIV=3 ----------------
  int   rise3_cnt, per3_bad, hi3_bad, mosi3_bad, cs3_bad, hi3_len, last3_rise;
  bit   in3_stream;
  logic s3_prev, m3_prev;

  initial begin
    rise3_cnt = 0; per3_bad = 0; hi3_bad = 0; mosi3_bad = 0; cs3_bad = 0;
    hi3_len = 0; last3_rise = -1; in3_stream = 1'b0; s3_prev = 1'b0; m3_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst3_n) begin
        if (dc3 && !cs3_n) in3_stream = 1'b1;
        if (in3_stream) begin
          if (cs3_n) cs3_bad++;
          if (sclk3 && !s3_prev) begin
            rise3_cnt++;
            if (mosi3 !== m3_prev) mosi3_bad++;
            if (last3_rise >= 0 && (cyc - last3_rise) != 6) per3_bad++;
            last3_rise = cyc;
          end
          if (sclk3) begin
            hi3_len++;
          end else if (s3_prev) begin
            if (hi3_len != 3) hi3_bad++;
            hi3_len = 0;
          end
        end
      end
      s3_prev = sclk3;
      m3_prev = mosi3;
    end
  end

  function automatic logic [7:0] qget(input int i, input bit from_data);
    if (from_data) return (i < data_bytes.size()) ? data_bytes[i] : 8'hxx;
    return (i < init_bytes.size()) ? init_bytes[i] : 8'hxx;
  endfunction

  typedef struct packed {
    logic [15:0] idx;
    logic [7:0]  exp;
  } vec_t;

  logic [7:0] rom_exp [31];
  vec_t       dvec [11];
  int         lo, hi, nz;

  task automatic check_init(input string tag);
    check({tag, "_init_count"}, 32'(init_bytes.size()), 32'd31);
    for (int i = 0; i < 31; i++) begin
      check($sformatf("%s_init_%0d", tag, i), 32'(qget(i, 1'b0)), 32'(rom_exp[i]));
    end
  endtask

  initial begin
    rom_exp = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF};
    // data byte index -> {page, column[4:0]}
    dvec[0]  = '{16'd0,    8'h00};
    dvec[1]  = '{16'd1,    8'h01};
    dvec[2]  = '{16'd31,   8'h1F};
    dvec[3]  = '{16'd32,   8'h00};
    dvec[4]  = '{16'd127,  8'h1F};
    dvec[5]  = '{16'd128,  8'h20};
    dvec[6]  = '{16'd129,  8'h21};
    dvec[7]  = '{16'd200,  8'h28};
    dvec[8]  = '{16'd1023, 8'hFF};
    dvec[9]  = '{16'd1024, 8'h00};
    dvec[10] = '{16'd1025, 8'h01};

    n_cmp = 0; n_bad = 0; mode = 1'b0;
    rst_n = 1'b0; rst3_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_res_n", 32'(res_n), 32'd0);
    check("rst_cs_n",  32'(cs_n),  32'd1);
    check("rst_sclk",  32'(sclk),  32'd0);
    check("rst_mosi",  32'(mosi),  32'd0);
    check("rst_dc",    32'(dc),    32'd0);
    check("rst_scan",  32'({row, col}), 32'd0);

    rst_n = 1'b1; rst3_n = 1'b1;
    lo = 0;
    do begin @(posedge clk); #1; lo++; end while (res_n == 1'b0 && lo < 50);
    check("res_low_clks", 32'(lo), 32'd4);
    hi = 0;
    do begin @(posedge clk); #1; hi++; end while (cs_n == 1'b1 && hi < 50);
    check("res_high_clks", 32'(hi), 32'd4);

    for (int i = 0; i < 70000 && (wrap_bytes.size() < 2 || data_bytes.size() < 1030); i++)
      @(negedge clk);
    check("phase1_collected", 32'(wrap_bytes.size() >= 2 && data_bytes.size() >= 1030), 32'd1);

    check_init("p1");
    for (int i = 0; i < 11; i++) begin
      check($sformatf("data_byte_%0d", dvec[i].idx), 32'(qget(int'(dvec[i].idx), 1'b1)),
            32'(dvec[i].exp));
    end
    check("frame_bytes", 32'((wrap_bytes.size() >= 2) ? wrap_bytes[1] - wrap_bytes[0] : -1), 32'd1024);
    check("frame_pulses_0", 32'((wrap_pulses.size() >= 1) ? wrap_pulses[0] : -1), 32'd1);
    check("frame_pulses_1", 32'((wrap_pulses.size() >= 2) ? wrap_pulses[1] : -1), 32'd1);
    check("prime_to_first_rise", 32'(got_rise ? t_rise - t_prime : -1), 32'd17);

    // Asynchronous reset in the middle of a streamed byte.
    for (int i = 0; i < 100 && !(sclk === 1'b1 && dc === 1'b1 && cs_n === 1'b0); i++)
      @(negedge clk);
    check("midbyte_sclk_high", 32'(sclk), 32'd1);
    #1 rst_n = 1'b0;
    mode = 1'b1;
    #1;
    check("async_cs_n",  32'(cs_n),  32'd1);
    check("async_sclk",  32'(sclk),  32'd0);
    check("async_res_n", 32'(res_n), 32'd0);
    check("async_scan",  32'({row, col}), 32'd0);
    check("async_dc",    32'(dc),    32'd0);
    check("async_mosi",  32'(mosi),  32'd0);
    repeat (2) @(negedge clk);
    init_bytes.delete();
    data_bytes.delete();
    got_prime = 1'b0;
    got_rise = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25000 && data_bytes.size() < 1024; i++) @(negedge clk);
    check("phase2_collected", 32'(data_bytes.size() >= 1024), 32'd1);
    check_init("p2");
    for (int p = 0; p < 8; p++) begin
      check($sformatf("img_page%0d_col37", p), 32'(qget(p * 128 + 37, 1'b1)), 32'hFF);
    end
    check("img_col36", 32'(qget(36, 1'b1)), 32'h00);
    check("img_col38", 32'(qget(38, 1'b1)), 32'h00);
    nz = 0;
    for (int k = 0; k < 1024; k++) if (qget(k, 1'b1) !== 8'h00) nz++;
    check("img_nonzero_bytes", 32'(nz), 32'd8);

    check("div3_rises_seen", 32'(rise3_cnt > 1000), 32'd1);
    check("div3_period_bad", 32'(per3_bad), 32'd0);
    check("div3_high_bad", 32'(hi3_bad), 32'd0);
    check("div3_mosi_bad", 32'(mosi3_bad), 32'd0);
    check("div3_cs_bad", 32'(cs3_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
